l_driver: RTL and testbench
===========================

# l_driver

Left-lane serial transmitter driving lane 0 of the 2-bit generic interconnect bus `iBus[0:1]`. It accepts parallel words through a valid/ready handshake and shifts them onto a single line as start bit, data (LSB first), optional even-parity bit and stop bit. It releases the line through an output enable when it is idle and disabled. The far end of the lane is received by the `lMod` side of `rlMod`, and `rDriver` is the mirror instance on lane 1.

## Interface
- `WIDTH`, 8: data word width, ≥1.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit, ≥1.
- `PARITY_EN`, 1: 1 inserts an even-parity bit; 0 omits it.

One clock; reset is synchronous and active-high.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  line drive enable while idle.
- `tx_data`  in  WIDTH  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a word.
- `line_out`  out  1  serial line value (to `iBus[0]`).
- `line_oe`  out  1  1 = drive `line_out`; 0 = release the line.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  single-cycle pulse at the end of a frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE behaviour:
  - `tx_ready` = 1, `busy` = 0, `line_out` = 1, `line_oe` = `en`.
  - On `tx_valid & tx_ready`, latch `tx_data` into the shift register and compute parity = XOR of all data bits. Go to START.
- START: `line_out` = 0.
- DATA:
  - `line_out` = shift register bit 0.
  - Shift right after each bit period.
  - Leave after WIDTH bits, to PARITY if `PARITY_EN`, else to STOP.
- PARITY: `line_out` = parity bit, so the total number of 1s over data plus parity is even.
- STOP: `line_out` = 1. On the last cycle of the period, pulse `frame_done` and go to IDLE.
- Every non-IDLE state:
  - lasts exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded on each state or bit change;
  - drives `line_oe` = 1, `busy` = 1, `tx_ready` = 0.
- `en` has no effect during a frame; a frame always completes.
- `tx_data` and `tx_valid` changes during a frame are ignored; only the latched word is sent.
- Reset:
  - Any cycle with `rst` = 1 forces IDLE, clears the counters and shift register, and aborts any frame in progress.
  - `tx_ready` = 0 while `rst` is high.
- Reset values: `line_out` = 1, `line_oe` = 0, `busy` = 0, `frame_done` = 0, `tx_ready` = 0.

## Timing
- All outputs are registered, except `tx_ready`, which is decoded from the state and gated by `rst`.
- Handshake accepted at edge N: `line_out` = 0 from the cycle after edge N.
- Frame length F = (WIDTH + 2 + PARITY_EN) × CLKS_PER_BIT cycles.
  - `busy` is high for exactly F cycles.
  - `frame_done` is high in the F-th cycle.
- `tx_ready` returns in the cycle after the `frame_done` cycle, so back-to-back frames have at least 1 idle cycle (`line_out` = 1) between them.
- CLKS_PER_BIT = 1: each bit lasts exactly one cycle, with no extra cycles.
- After `rst` deasserts, `tx_ready` = 1 in the first cycle with `rst` = 0.

## Test plan
- Basic frame: reset, `en` = 1, then send 0xA5 (WIDTH = 8, CLKS_PER_BIT = 4, PARITY_EN = 1).
  - Line sequence, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 0 | 1.
  - `busy` high for 44 cycles; `frame_done` high on cycle 44.
- Odd data: send 0x07.
  - Parity bit = 1.
  - Send 0x00: parity bit = 0, and the data bits are all 0.
- Back-to-back: hold `tx_valid` high with 0x3C, then 0xC3.
  - The second word is accepted exactly 1 cycle after the first `frame_done`.
  - The line stays 1 for that cycle.
- Line release and enable:
  - `en` = 0 in IDLE: `line_oe` = 0.
  - Start a frame, then drop `en` mid-frame: `line_oe` stays 1 until the frame ends, then goes to 0.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - Next cycle: `line_out` = 1, `line_oe` = 0, `busy` = 0, no `frame_done` pulse.
  - After release, a new frame for 0x5A is sent correctly.
- PARITY_EN = 0, CLKS_PER_BIT = 1: send 0x81.
  - Frame = 10 cycles: 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/l_driver_if.sv
// l_driver_if: word handshake between a producer and the lane-0 serial driver.
//   tx_data   word to send (producer -> driver)
//   tx_valid  tx_data is valid (producer -> driver)
//   tx_ready  driver can accept a word (driver -> producer)
// Modports: master = word producer, slave = l_driver.
interface l_driver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/l_driver.sv
// l_driver: left-lane serial transmitter for lane 0 of iBus[0:1].
// Sends each accepted word as start bit (0), data LSB first, optional even
// parity bit and stop bit (1), every bit held for CLKS_PER_BIT cycles.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   en          line drive enable while idle
//   tx          word handshake (slave side: tx_data, tx_valid, tx_ready)
//   line_out    serial line value (to iBus[0])
//   line_oe     1 = drive line_out, 0 = release the line
//   busy        a frame is in progress
//   frame_done  single-cycle pulse in the last cycle of a frame
module l_driver #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    l_driver_if.slave   tx,
    output logic        line_out,
    output logic        line_oe,
    output logic        busy,
    output logic        frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             parity, parity_n;
    logic             line_n;

    // Ready is the only combinational output: idle and not held in reset.
    assign tx.tx_ready = (state == IDLE) && !rst;

    // Next-state logic. Every non-idle state counts its bit period down to
    // zero and only then advances; the counter is reloaded on every change.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        parity_n  = parity;
        if (state != IDLE && cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (tx.tx_valid && tx.tx_ready) begin
                        shreg_n  = tx.tx_data;
                        parity_n = ^tx.tx_data;
                        state_n  = START;
                        cnt_n    = CNT_MAX;
                    end
                end
                START: begin
                    state_n   = DATA;
                    cnt_n     = CNT_MAX;
                    bit_cnt_n = '0;
                end
                DATA: begin
                    cnt_n = CNT_MAX;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        shreg_n   = shreg >> 1;
                    end
                end
                PARITY: begin
                    state_n = STOP;
                    cnt_n   = CNT_MAX;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Line value for the state being entered, so the registered output
    // lines up with the state register.
    always_comb begin
        line_n = 1'b1;
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shreg_n[0];
            PARITY:  line_n = parity_n;
            default: line_n = 1'b1;
        endcase
    end

    // State and registered outputs; frame_done is raised on entry to the
    // final cycle of the stop bit so it coincides with that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            line_out   <= 1'b1;
            line_oe    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            parity     <= parity_n;
            line_out   <= line_n;
            line_oe    <= (state_n != IDLE) || en;
            busy       <= (state_n != IDLE);
            frame_done <= (state_n == STOP) && (cnt_n == '0);
        end
    end

endmodule

// File: tb/tb_l_driver.sv
// tb_l_driver: directed self-checking bench for l_driver.
// Instance a: WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1.
// Instance b: WIDTH=8, CLKS_PER_BIT=1, PARITY_EN=0.
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_l_driver;

    logic clk;
    logic rst;
    logic en;
    logic line_a, oe_a, busy_a, done_a;
    logic line_b, oe_b, busy_b, done_b;
    int   total;
    int   bad;

    l_driver_if #(.WIDTH(8)) tx_a ();
    l_driver_if #(.WIDTH(8)) tx_b ();

    l_driver #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tx         (tx_a),
        .line_out   (line_a),
        .line_oe    (oe_a),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    l_driver #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tx         (tx_b),
        .line_out   (line_b),
        .line_oe    (oe_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic valid);
        tx_a.tx_data  = data;
        tx_a.tx_valid = valid;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Sends one word on instance a and checks all 44 frame cycles plus the
    // following idle cycle. exp_par is the hand-computed parity bit.
    task automatic runFrameA(input logic [7:0] data, input logic exp_par,
                             input logic hold, input logic [7:0] next_data,
                             input int drop_en_at, input logic exp_oe_end);
        logic exp_line;
        int   k;
        applyStimulus(data, 1'b1);
        tick();
        applyStimulus(next_data, hold);
        for (int c = 1; c <= 44; c++) begin
            k = (c - 1) / 4;
            if (k == 0)      exp_line = 1'b0;
            else if (k <= 8) exp_line = data[k-1];
            else if (k == 9) exp_line = exp_par;
            else             exp_line = 1'b1;
            checkOutput($sformatf("a_line %02h c%0d", data, c), line_a, exp_line);
            checkOutput($sformatf("a_oe %02h c%0d", data, c), oe_a, 1'b1);
            checkOutput($sformatf("a_busy %02h c%0d", data, c), busy_a, 1'b1);
            checkOutput($sformatf("a_done %02h c%0d", data, c), done_a, (c == 44));
            checkOutput($sformatf("a_ready %02h c%0d", data, c), tx_a.tx_ready, 1'b0);
            if (c == drop_en_at) en = 1'b0;
            tick();
        end
        checkOutput($sformatf("a_end_busy %02h", data), busy_a, 1'b0);
        checkOutput($sformatf("a_end_done %02h", data), done_a, 1'b0);
        checkOutput($sformatf("a_end_ready %02h", data), tx_a.tx_ready, 1'b1);
        checkOutput($sformatf("a_end_line %02h", data), line_a, 1'b1);
        checkOutput($sformatf("a_end_oe %02h", data), oe_a, exp_oe_end);
    endtask

    initial begin
        logic [9:0] exp_b;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        tx_a.tx_data  = 8'h00;
        tx_a.tx_valid = 1'b0;
        tx_b.tx_data  = 8'h00;
        tx_b.tx_valid = 1'b0;
        $display("[TB] start");

        tick();
        tick();
        checkOutput("rst_line_a", line_a, 1'b1);
        checkOutput("rst_oe_a", oe_a, 1'b0);
        checkOutput("rst_busy_a", busy_a, 1'b0);
        checkOutput("rst_done_a", done_a, 1'b0);
        checkOutput("rst_ready_a", tx_a.tx_ready, 1'b0);
        checkOutput("rst_oe_b", oe_b, 1'b0);
        checkOutput("rst_ready_b", tx_b.tx_ready, 1'b0);

        rst = 1'b0;
        en  = 1'b1;
        #1;
        checkOutput("ready_after_rst_a", tx_a.tx_ready, 1'b1);
        checkOutput("ready_after_rst_b", tx_b.tx_ready, 1'b1);
        tick();
        checkOutput("idle_oe_en1", oe_a, 1'b1);
        checkOutput("idle_line", line_a, 1'b1);

        en = 1'b0;
        tick();
        checkOutput("idle_oe_en0_a", oe_a, 1'b0);
        checkOutput("idle_oe_en0_b", oe_b, 1'b0);
        en = 1'b1;
        tick();
        checkOutput("idle_oe_en1_again", oe_a, 1'b1);

        $display("[TB] basic and parity frames");
        runFrameA(8'hA5, 1'b0, 1'b0, 8'h00, 0, 1'b1);
        runFrameA(8'h07, 1'b1, 1'b0, 8'h00, 0, 1'b1);
        runFrameA(8'h00, 1'b0, 1'b0, 8'h00, 0, 1'b1);

        $display("[TB] back-to-back");
        runFrameA(8'h3C, 1'b0, 1'b1, 8'hC3, 0, 1'b1);
        runFrameA(8'hC3, 1'b0, 1'b0, 8'h00, 0, 1'b1);

        $display("[TB] enable dropped mid-frame");
        runFrameA(8'h96, 1'b0, 1'b0, 8'h00, 20, 1'b0);
        en = 1'b1;
        tick();
        checkOutput("oe_restored", oe_a, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hFF, 1'b1);
        tick();
        applyStimulus(8'h00, 1'b0);
        repeat (17) tick();
        checkOutput("pre_rst_busy", busy_a, 1'b1);
        checkOutput("pre_rst_line", line_a, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready", tx_a.tx_ready, 1'b0);
        tick();
        checkOutput("post_rst_line", line_a, 1'b1);
        checkOutput("post_rst_oe", oe_a, 1'b0);
        checkOutput("post_rst_busy", busy_a, 1'b0);
        checkOutput("post_rst_done", done_a, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", tx_a.tx_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("post_rst_idle_done %0d", i), done_a, 1'b0);
            checkOutput($sformatf("post_rst_idle_busy %0d", i), busy_a, 1'b0);
        end
        runFrameA(8'h5A, 1'b0, 1'b0, 8'h00, 0, 1'b1);

        $display("[TB] no parity, one clock per bit");
        exp_b = 10'b1100000010;
        tx_b.tx_data  = 8'h81;
        tx_b.tx_valid = 1'b1;
        tick();
        tx_b.tx_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checkOutput($sformatf("b_line c%0d", c), line_b, exp_b[c-1]);
            checkOutput($sformatf("b_busy c%0d", c), busy_b, 1'b1);
            checkOutput($sformatf("b_done c%0d", c), done_b, (c == 10));
            tick();
        end
        checkOutput("b_end_busy", busy_b, 1'b0);
        checkOutput("b_end_ready", tx_b.tx_ready, 1'b1);
        checkOutput("b_end_line", line_b, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
